// File: rtl/rr_grant_arbiter.sv
// Round-robin arbiter: one owner at a time, priority rotating downward from the
// last owner, registered one-hot grant, optional bound on consecutive grant cycles.
module rr_grant_arbiter #(
  parameter int N        = 8,
  parameter int IDXW     = $clog2(N),
  parameter int MAX_HOLD = 16,
  parameter int CNTW     = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req,
  output logic [N-1:0]    gnt,
  output logic            gnt_valid,
  output logic [IDXW-1:0] gnt_idx,
  output logic            grant_start
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  localparam logic [CNTW-1:0] CNT_ONE  = CNTW'(1);
  // With no hold limit the counter just parks at its all-ones value.
  localparam logic [CNTW-1:0] CNT_SAT  = (MAX_HOLD == 0) ? {CNTW{1'b1}} : CNTW'(MAX_HOLD);
  localparam logic [N-1:0]    ONE_HOT0 = {{(N-1){1'b0}}, 1'b1};

  // Highest-set-bit encoder: returns {found, index}.
  function automatic logic [IDXW:0] hsb_enc(input logic [N-1:0] vec);
    logic [IDXW:0] res;
    res = {1'b0, {IDXW{1'b0}}};
    for (int i = 0; i < N; i++) begin
      res = vec[i] ? {1'b1, IDXW'(i)} : res;
    end
    return res;
  endfunction

  state_t          state_r, state_nxt_s;
  logic [IDXW-1:0] last_idx_r, last_idx_nxt_s;
  logic [CNTW-1:0] cnt_r, cnt_nxt_s;
  logic [N-1:0]    gnt_nxt_s;
  logic            gnt_valid_nxt_s;
  logic [IDXW-1:0] gnt_idx_nxt_s;
  logic            grant_start_nxt_s;

  logic [N-1:0]    low_mask_s;
  logic [N-1:0]    masked_s;
  logic [IDXW:0]   masked_enc_s;
  logic [IDXW:0]   raw_enc_s;
  logic            win_valid_s;
  logic [IDXW-1:0] win_idx_s;
  logic            hold_expired_s;
  logic            release_s;

  // Candidate selection: masked (strictly below last owner) first, raw request otherwise.
  always_comb begin
    low_mask_s = {N{1'b0}};
    for (int i = 0; i < N; i++) begin
      low_mask_s[i] = (i < int'(last_idx_r));
    end
    masked_s       = req & low_mask_s;
    masked_enc_s   = hsb_enc(masked_s);
    raw_enc_s      = hsb_enc(req);
    win_valid_s    = masked_enc_s[IDXW] | raw_enc_s[IDXW];
    win_idx_s      = masked_enc_s[IDXW] ? masked_enc_s[IDXW-1:0] : raw_enc_s[IDXW-1:0];
    hold_expired_s = (MAX_HOLD != 0) && (cnt_r == CNT_SAT);
    release_s      = ~req[gnt_idx] | hold_expired_s;
  end

  // Next-state and next-output decode for the ownership FSM.
  always_comb begin
    state_nxt_s       = state_r;
    last_idx_nxt_s    = last_idx_r;
    cnt_nxt_s         = cnt_r;
    gnt_nxt_s         = gnt;
    gnt_valid_nxt_s   = gnt_valid;
    gnt_idx_nxt_s     = gnt_idx;
    grant_start_nxt_s = 1'b0;

    case (state_r)
      ST_IDLE: begin
        if (win_valid_s) begin
          state_nxt_s       = ST_GRANT;
          gnt_nxt_s         = ONE_HOT0 << win_idx_s;
          gnt_valid_nxt_s   = 1'b1;
          gnt_idx_nxt_s     = win_idx_s;
          grant_start_nxt_s = 1'b1;
          cnt_nxt_s         = CNT_ONE;
          last_idx_nxt_s    = win_idx_s;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_GRANT: begin
        if (!release_s) begin
          cnt_nxt_s = (cnt_r == CNT_SAT) ? cnt_r : cnt_r + CNT_ONE;
        end else if (win_valid_s) begin
          // Back-to-back handover; may be the same requester after a timeout.
          gnt_nxt_s         = ONE_HOT0 << win_idx_s;
          gnt_valid_nxt_s   = 1'b1;
          gnt_idx_nxt_s     = win_idx_s;
          grant_start_nxt_s = 1'b1;
          cnt_nxt_s         = CNT_ONE;
          last_idx_nxt_s    = win_idx_s;
        end else begin
          state_nxt_s     = ST_IDLE;
          gnt_nxt_s       = {N{1'b0}};
          gnt_valid_nxt_s = 1'b0;
          gnt_idx_nxt_s   = {IDXW{1'b0}};
          cnt_nxt_s       = {CNTW{1'b0}};
        end
      end
      default: begin
        state_nxt_s     = ST_IDLE;
        gnt_nxt_s       = {N{1'b0}};
        gnt_valid_nxt_s = 1'b0;
        gnt_idx_nxt_s   = {IDXW{1'b0}};
        cnt_nxt_s       = {CNTW{1'b0}};
      end
    endcase
  end

  // State and registered outputs, cleared immediately by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      last_idx_r  <= {IDXW{1'b0}};
      cnt_r       <= {CNTW{1'b0}};
      gnt         <= {N{1'b0}};
      gnt_valid   <= 1'b0;
      gnt_idx     <= {IDXW{1'b0}};
      grant_start <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      last_idx_r  <= last_idx_nxt_s;
      cnt_r       <= cnt_nxt_s;
      gnt         <= gnt_nxt_s;
      gnt_valid   <= gnt_valid_nxt_s;
      gnt_idx     <= gnt_idx_nxt_s;
      grant_start <= grant_start_nxt_s;
    end
  end

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Self-checking bench for rr_grant_arbiter: directed vector table, multi-cycle
// sequences and randomized traffic against a rotating-priority reference model.
module tb_rr_grant_arbiter;

  localparam int N  = 4;
  localparam int IW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic [N-1:0]  req_a, req_b, gnt_a, gnt_b;
  logic          valid_a, valid_b, start_a, start_b;
  logic [IW-1:0] idx_a, idx_b;

  rr_grant_arbiter #(.N(N), .MAX_HOLD(3)) dut_a (
    .clk(clk), .rst_n(rst_n), .req(req_a), .gnt(gnt_a),
    .gnt_valid(valid_a), .gnt_idx(idx_a), .grant_start(start_a)
  );

  rr_grant_arbiter #(.N(N), .MAX_HOLD(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .req(req_b), .gnt(gnt_b),
    .gnt_valid(valid_b), .gnt_idx(idx_b), .grant_start(start_b)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference model: owner -1 means idle; priority scans downward from last owner.
  int m_owner[2];
  int m_last[2];
  int m_cnt[2];
  bit m_start[2];
  int m_hold[2] = '{3, 0};

  function automatic int pick(input int last, input logic [N-1:0] r);
    for (int k = last - 1; k >= 0; k--) if (r[k]) return k;
    for (int k = N - 1; k >= 0; k--) if (r[k]) return k;
    return -1;
  endfunction

  task automatic model_reset();
    for (int u = 0; u < 2; u++) begin
      m_owner[u] = -1; m_last[u] = 0; m_cnt[u] = 0; m_start[u] = 1'b0;
    end
  endtask

  task automatic model_step(input int u, input logic [N-1:0] r);
    int w;
    bit rel;
    m_start[u] = 1'b0;
    if (m_owner[u] < 0) rel = 1'b1;
    else rel = !r[m_owner[u]] || (m_hold[u] != 0 && m_cnt[u] == m_hold[u]);
    if (!rel) begin
      m_cnt[u]++;
    end else begin
      w = pick(m_last[u], r);
      if (w >= 0) begin
        m_owner[u] = w; m_last[u] = w; m_cnt[u] = 1; m_start[u] = 1'b1;
      end else begin
        m_owner[u] = -1; m_cnt[u] = 0;
      end
    end
  endtask

  task automatic check_model(input int u, input int cyc, input logic [N-1:0] g,
                             input logic v, input logic [IW-1:0] ix, input logic s);
    logic [N-1:0] eg;
    eg = (m_owner[u] < 0) ? 4'b0000 : (4'b0001 << m_owner[u]);
    check($sformatf("rnd_u%0d_c%0d_gnt", u, cyc), 32'(g), 32'(eg));
    check($sformatf("rnd_u%0d_c%0d_valid", u, cyc), 32'(v), 32'(m_owner[u] >= 0));
    check($sformatf("rnd_u%0d_c%0d_idx", u, cyc), 32'(ix), (m_owner[u] < 0) ? 32'd0 : 32'(m_owner[u]));
    check($sformatf("rnd_u%0d_c%0d_start", u, cyc), 32'(s), 32'(m_start[u]));
  endtask

  // Drive requests, take one rising edge, then settle at the falling edge.
  task automatic step(input logic [N-1:0] ra, input logic [N-1:0] rb);
    req_a = ra;
    req_b = rb;
    @(posedge clk);
    model_step(0, ra);
    model_step(1, rb);
    @(negedge clk);
  endtask

  task automatic do_reset();
    req_a = 4'b0000;
    req_b = 4'b0000;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  typedef struct packed {
    logic [N-1:0]  req;
    logic [N-1:0]  gnt;
    logic          valid;
    logic [IW-1:0] idx;
    logic          start;
  } vec_t;

  vec_t tbl[15];
  int   own3[15] = '{3, 3, 3, 2, 2, 2, 1, 1, 1, 0, 0, 0, 3, 3, 3};
  logic [N-1:0] ra, rb;

  initial begin
    // Expected outputs after the edge that samples .req (MAX_HOLD=3 unit).
    tbl[0]  = '{4'b0101, 4'b0100, 1'b1, 2'd2, 1'b1};
    tbl[1]  = '{4'b0101, 4'b0100, 1'b1, 2'd2, 1'b0};
    tbl[2]  = '{4'b0001, 4'b0001, 1'b1, 2'd0, 1'b1};
    tbl[3]  = '{4'b0001, 4'b0001, 1'b1, 2'd0, 1'b0};
    tbl[4]  = '{4'b0001, 4'b0001, 1'b1, 2'd0, 1'b0};
    tbl[5]  = '{4'b0001, 4'b0001, 1'b1, 2'd0, 1'b1};
    tbl[6]  = '{4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0};
    tbl[7]  = '{4'b0010, 4'b0010, 1'b1, 2'd1, 1'b1};
    tbl[8]  = '{4'b1010, 4'b0010, 1'b1, 2'd1, 1'b0};
    tbl[9]  = '{4'b1000, 4'b1000, 1'b1, 2'd3, 1'b1};
    tbl[10] = '{4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0};
    tbl[11] = '{4'b0010, 4'b0010, 1'b1, 2'd1, 1'b1};
    tbl[12] = '{4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0};
    tbl[13] = '{4'b1010, 4'b1000, 1'b1, 2'd3, 1'b1};
    tbl[14] = '{4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0};

    // Reset held with every requester active.
    rst_n = 1'b0;
    req_a = 4'b1111;
    req_b = 4'b1111;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_gnt_a", 32'(gnt_a), 32'd0);
    check("rst_valid_a", 32'(valid_a), 32'd0);
    check("rst_idx_a", 32'(idx_a), 32'd0);
    check("rst_start_a", 32'(start_a), 32'd0);
    check("rst_gnt_b", 32'(gnt_b), 32'd0);

    // Reset asserted mid-grant drops gnt without waiting for an edge.
    rst_n = 1'b1;
    step(4'b1111, 4'b0000);
    check("pre_rst_gnt", 32'(gnt_a), 32'h8);
    step(4'b1111, 4'b0000);
    rst_n = 1'b0;
    #1;
    check("midrst_gnt", 32'(gnt_a), 32'd0);
    check("midrst_valid", 32'(valid_a), 32'd0);
    check("midrst_idx", 32'(idx_a), 32'd0);
    do_reset();

    for (int i = 0; i < 15; i++) begin
      step(tbl[i].req, 4'b0000);
      check($sformatf("tbl%0d_gnt", i), 32'(gnt_a), 32'(tbl[i].gnt));
      check($sformatf("tbl%0d_valid", i), 32'(valid_a), 32'(tbl[i].valid));
      check($sformatf("tbl%0d_idx", i), 32'(idx_a), 32'(tbl[i].idx));
      check($sformatf("tbl%0d_start", i), 32'(start_a), 32'(tbl[i].start));
    end

    // All requesting: rotation 3,2,1,0,3 with exactly MAX_HOLD cycles each.
    do_reset();
    for (int i = 0; i < 15; i++) begin
      step(4'b1111, 4'b0000);
      check($sformatf("rot%0d_gnt", i), 32'(gnt_a), 32'd1 << own3[i]);
      check($sformatf("rot%0d_idx", i), 32'(idx_a), 32'(own3[i]));
      check($sformatf("rot%0d_start", i), 32'(start_a), 32'(i % 3 == 0));
    end

    // Lone requester is re-granted on every timeout without a gap.
    do_reset();
    for (int i = 0; i < 9; i++) begin
      step(4'b0010, 4'b0000);
      check($sformatf("solo%0d_gnt", i), 32'(gnt_a), 32'h2);
      check($sformatf("solo%0d_valid", i), 32'(valid_a), 32'd1);
      check($sformatf("solo%0d_start", i), 32'(start_a), 32'(i % 3 == 0));
    end

    // Unlimited hold keeps the owner, then hands over once it lets go.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      step(4'b0000, 4'b1001);
      check($sformatf("nolim%0d_gnt", i), 32'(gnt_b), 32'h8);
    end
    step(4'b0000, 4'b0001);
    check("nolim_hand_gnt", 32'(gnt_b), 32'h1);
    check("nolim_hand_idx", 32'(idx_b), 32'd0);
    check("nolim_hand_start", 32'(start_b), 32'd1);

    // Randomized traffic on both units against the model.
    do_reset();
    ra = 4'b0000;
    rb = 4'b0000;
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 3) == 0) ra = 4'($urandom);
      if ($urandom_range(0, 3) == 0) rb = 4'($urandom);
      step(ra, rb);
      check_model(0, c, gnt_a, valid_a, idx_a, start_a);
      check_model(1, c, gnt_b, valid_b, idx_b, start_b);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
